// File: rtl/reg_scoreboard_ctrl_pkg.sv
// reg_scoreboard_ctrl_pkg: shared instruction-definition constants and helpers for the register scoreboard
package reg_scoreboard_ctrl_pkg;
  localparam int DEF_LEN_REG = 32;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_LEN_REGNO = 3;
  localparam int DEF_NUM_FU = 2;
  typedef enum logic [1:0] {
    XFER_NONE,
    XFER_WB,
    XFER_ERR
  } xfer_e;
  function automatic int unsigned next_rr(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/reg_scoreboard_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant with a priority pointer that moves past each winner
module rr_arbiter
  import reg_scoreboard_ctrl_pkg::*;
#(
  parameter int NUM_FU = DEF_NUM_FU,
  localparam int IW = NUM_FU > 1 ? $clog2(NUM_FU) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_FU-1:0] req,
  output logic [NUM_FU-1:0] gnt,
  output logic              gnt_any
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] k;
  logic [IW-1:0] gnt_idx;
  // first requester found scanning upward from the pointer, wrapping around
  always_comb begin
    gnt = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    k = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      k = IW'((int'(ptr) + i) % NUM_FU);
      if (!gnt_any && req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = k;
        gnt[k] = 1'b1;
      end
    end
  end
  // pointer advances to the slot after the winner on every grant
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (gnt_any) ptr <= IW'(next_rr(int'(gnt_idx), NUM_FU));
endmodule

// File: rtl/reg_scoreboard_ctrl.sv
// reg_scoreboard_ctrl: issue hazard check, reservation request and arbitrated FU writeback for a register file
module reg_scoreboard_ctrl
  import reg_scoreboard_ctrl_pkg::*;
#(
  parameter int LEN_REG = DEF_LEN_REG,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int LEN_REGNO = DEF_LEN_REGNO,
  parameter int NUM_FU = DEF_NUM_FU
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [LEN_REGNO-1:0]      issue_rs1_i,
  input  logic [LEN_REGNO-1:0]      issue_rs2_i,
  input  logic [LEN_REGNO-1:0]      issue_rd_i,
  input  logic                      issue_use_rs1_i,
  input  logic                      issue_use_rs2_i,
  input  logic                      issue_wr_i,
  input  logic [NUM_REGS-1:0]       reserve_i,
  output logic [NUM_REGS-1:0]       w_reserve_o,
  input  logic [NUM_FU-1:0]         fu_valid_i,
  output logic [NUM_FU-1:0]         fu_ready_o,
  input  logic [NUM_FU*LEN_REGNO-1:0] fu_rd_i,
  input  logic [NUM_FU*LEN_REG-1:0] fu_data_i,
  output logic [NUM_REGS-1:0]       wb_o,
  output logic [LEN_REG-1:0]        wb_data_o,
  output logic                      err_o,
  output logic [15:0]               stall_cnt_o
);
  logic [NUM_REGS-1:0] rs1_oh, rs2_oh, rd_oh, fu_oh;
  logic [LEN_REGNO-1:0] sel_rd;
  logic [LEN_REG-1:0] sel_data;
  logic bad_issue, hazard, gnt_any;
  xfer_e xfer;
  rr_arbiter #(.NUM_FU(NUM_FU)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(fu_valid_i),
    .gnt(fu_ready_o),
    .gnt_any(gnt_any)
  );
  // out-of-range numbers shift out to an all-zero one-hot, so they never match a reservation
  assign rs1_oh = NUM_REGS'(1) << issue_rs1_i;
  assign rs2_oh = NUM_REGS'(1) << issue_rs2_i;
  assign rd_oh = NUM_REGS'(1) << issue_rd_i;
  assign bad_issue = (issue_use_rs1_i && int'(issue_rs1_i) >= NUM_REGS) ||
                     (issue_use_rs2_i && int'(issue_rs2_i) >= NUM_REGS) ||
                     (issue_wr_i && int'(issue_rd_i) >= NUM_REGS);
  assign hazard = |(reserve_i & ((issue_use_rs1_i ? rs1_oh : '0) |
                                 (issue_use_rs2_i ? rs2_oh : '0) |
                                 (issue_wr_i ? rd_oh : '0)));
  assign issue_ready_o = !(hazard || bad_issue);
  assign w_reserve_o = (issue_valid_i && issue_ready_o && issue_wr_i) ? rd_oh : '0;
  // route the granted FU's destination and data; grant is one-hot so at most one slice matches
  always_comb begin
    sel_rd = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (fu_ready_o[i]) begin
        sel_rd = fu_rd_i[i*LEN_REGNO +: LEN_REGNO];
        sel_data = fu_data_i[i*LEN_REG +: LEN_REG];
      end
  end
  assign fu_oh = NUM_REGS'(1) << sel_rd;
  assign xfer = !gnt_any ? XFER_NONE :
                (int'(sel_rd) < NUM_REGS && |(reserve_i & fu_oh)) ? XFER_WB : XFER_ERR;
  // writeback pulse, held data, sticky error and saturating stall counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_o <= '0;
      wb_data_o <= '0;
      err_o <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      wb_o <= xfer == XFER_WB ? fu_oh : '0;
      if (xfer == XFER_WB) wb_data_o <= sel_data;
      err_o <= err_o || xfer == XFER_ERR || (issue_valid_i && bad_issue);
      if (issue_valid_i && !issue_ready_o && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
endmodule

// File: tb/tb_reg_scoreboard_ctrl.sv
// tb_reg_scoreboard_ctrl: directed stimulus with a behavioural scoreboard model checked every cycle
module tb_reg_scoreboard_ctrl;
  localparam int NR = 8, NF = 2, RW = 3, DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue_valid_i = 1'b0, issue_ready_o;
  logic [RW-1:0] issue_rs1_i = '0, issue_rs2_i = '0, issue_rd_i = '0;
  logic issue_use_rs1_i = 1'b0, issue_use_rs2_i = 1'b0, issue_wr_i = 1'b0;
  logic [NR-1:0] reserve_i = '0, w_reserve_o, wb_o;
  logic [NF-1:0] fu_valid_i = '0, fu_ready_o;
  logic [NF*RW-1:0] fu_rd_i = '0;
  logic [NF*DW-1:0] fu_data_i = '0;
  logic [DW-1:0] wb_data_o;
  logic err_o;
  logic [15:0] stall_cnt_o;
  int checks = 0, errors = 0;
  int m_ptr = 0, m_stall = 0, n_ptr = 0, n_stall = 0;
  logic [NR-1:0] m_wb = '0, n_wb = '0;
  logic [DW-1:0] m_data = '0, n_data = '0;
  logic m_err = 1'b0, n_err = 1'b0;

  reg_scoreboard_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_rd_i(issue_rd_i),
    .issue_use_rs1_i(issue_use_rs1_i), .issue_use_rs2_i(issue_use_rs2_i), .issue_wr_i(issue_wr_i),
    .reserve_i(reserve_i), .w_reserve_o(w_reserve_o),
    .fu_valid_i(fu_valid_i), .fu_ready_o(fu_ready_o), .fu_rd_i(fu_rd_i), .fu_data_i(fu_data_i),
    .wb_o(wb_o), .wb_data_o(wb_data_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int g, r;
    logic hz, bad, rdy;
    hz = 1'b0;
    bad = 1'b0;
    if (issue_use_rs1_i) begin if (int'(issue_rs1_i) >= NR) bad = 1'b1; else if (reserve_i[issue_rs1_i]) hz = 1'b1; end
    if (issue_use_rs2_i) begin if (int'(issue_rs2_i) >= NR) bad = 1'b1; else if (reserve_i[issue_rs2_i]) hz = 1'b1; end
    if (issue_wr_i) begin if (int'(issue_rd_i) >= NR) bad = 1'b1; else if (reserve_i[issue_rd_i]) hz = 1'b1; end
    rdy = !(hz || bad);
    chk("issue_ready", 32'(issue_ready_o), 32'(rdy));
    chk("w_reserve", 32'(w_reserve_o), (issue_valid_i && rdy && issue_wr_i) ? 32'(1) << issue_rd_i : 32'(0));
    g = -1;
    for (int i = 0; i < NF; i++) if (g < 0 && fu_valid_i[(m_ptr + i) % NF]) g = (m_ptr + i) % NF;
    chk("fu_ready", 32'(fu_ready_o), g < 0 ? 32'(0) : 32'(1) << g);
    chk("wb", 32'(wb_o), 32'(m_wb));
    chk("wb_data", wb_data_o, m_data);
    chk("err", 32'(err_o), 32'(m_err));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    n_wb = '0;
    n_data = m_data;
    n_err = m_err;
    n_ptr = m_ptr;
    n_stall = m_stall;
    if (g >= 0) begin
      r = int'(fu_rd_i[g*RW +: RW]);
      if (r < NR && reserve_i[r]) begin
        n_wb = NR'(1) << r;
        n_data = fu_data_i[g*DW +: DW];
      end else n_err = 1'b1;
      n_ptr = (g + 1) % NF;
    end
    if (issue_valid_i && bad) n_err = 1'b1;
    if (issue_valid_i && !rdy && m_stall < 65535) n_stall = m_stall + 1;
  end

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_wb <= '0;
      m_data <= '0;
      m_err <= 1'b0;
      m_ptr <= 0;
      m_stall <= 0;
    end else begin
      m_wb <= n_wb;
      m_data <= n_data;
      m_err <= n_err;
      m_ptr <= n_ptr;
      m_stall <= n_stall;
    end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_wb", 32'(wb_o), 32'h0);
    chk("lit_rst_err", 32'(err_o), 32'h0);
    chk("lit_rst_stall", 32'(stall_cnt_o), 32'h0);
    rst = 1'b0;
    step();
    issue_valid_i = 1'b1; issue_rd_i = 3'd3; issue_wr_i = 1'b1; reserve_i = 8'h00;
    #1;
    chk("lit_issue_ready", 32'(issue_ready_o), 32'h1);
    chk("lit_w_reserve", 32'(w_reserve_o), 32'h08);
    step();
    issue_wr_i = 1'b0; issue_use_rs1_i = 1'b1; issue_rs1_i = 3'd3; reserve_i = 8'h08;
    #1;
    chk("lit_stall_ready", 32'(issue_ready_o), 32'h0);
    repeat (4) step();
    chk("lit_stall_cnt4", 32'(stall_cnt_o), 32'd4);
    issue_valid_i = 1'b0; issue_use_rs1_i = 1'b0;
    reserve_i = 8'h24; fu_rd_i = {3'd5, 3'd2}; fu_data_i = {32'h0000_00B1, 32'h0000_00A0}; fu_valid_i = 2'b11;
    #1;
    chk("lit_gnt0", 32'(fu_ready_o), 32'h1);
    step();
    chk("lit_wb0", 32'(wb_o), 32'h04);
    chk("lit_wbd0", wb_data_o, 32'hA0);
    chk("lit_gnt1", 32'(fu_ready_o), 32'h2);
    step();
    chk("lit_wb1", 32'(wb_o), 32'h20);
    chk("lit_wbd1", wb_data_o, 32'hB1);
    chk("lit_gnt2", 32'(fu_ready_o), 32'h1);
    issue_valid_i = 1'b1; issue_wr_i = 1'b1; issue_rd_i = 3'd7;
    #1;
    chk("lit_par_w_reserve", 32'(w_reserve_o), 32'h80);
    step();
    chk("lit_wb2", 32'(wb_o), 32'h04);
    fu_valid_i = 2'b00; issue_wr_i = 1'b0; issue_use_rs2_i = 1'b1; issue_rs2_i = 3'd2;
    #1;
    chk("lit_inflight_stall", 32'(issue_ready_o), 32'h0);
    step();
    issue_valid_i = 1'b0; issue_use_rs2_i = 1'b0;
    fu_rd_i = {3'd6, 3'd2}; fu_valid_i = 2'b10;
    step();
    chk("lit_err_wb", 32'(wb_o), 32'h0);
    chk("lit_err_set", 32'(err_o), 32'h1);
    fu_valid_i = 2'b00;
    repeat (3) step();
    chk("lit_err_hold", 32'(err_o), 32'h1);
    fu_valid_i = 2'b01;
    step();
    fu_valid_i = 2'b00; rst = 1'b1;
    #1;
    chk("lit_rst_cancel_wb", 32'(wb_o), 32'h0);
    chk("lit_rst_err_clr", 32'(err_o), 32'h0);
    chk("lit_rst_stall_clr", 32'(stall_cnt_o), 32'h0);
    step();
    rst = 1'b0; fu_valid_i = 2'b11;
    #1;
    chk("lit_rst_ptr", 32'(fu_ready_o), 32'h1);
    step();
    chk("lit_post_rst_wb", 32'(wb_o), 32'h04);
    fu_valid_i = 2'b00;
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard_ctrl.md
REG_SCOREBOARD_CTRL -- requirements
Module: reg_scoreboard_ctrl

Interface
REQ-001 SHALL have parameter LEN_REG, default 32, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 8, number of register cells controlled.
REQ-003 SHALL have parameter LEN_REGNO, default 3, register-number width, with log2(NUM_REGS) <= LEN_REGNO.
REQ-004 SHALL have parameter NUM_FU, default 2, number of functional-unit writeback requesters.
REQ-005 SHALL have port clk, input, 1, the only clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have ports issue_valid_i in 1 and issue_ready_o out 1; an issue fires when both are 1.
REQ-008 SHALL have ports issue_rs1_i, issue_rs2_i, issue_rd_i, each input LEN_REGNO, giving source and destination numbers.
REQ-009 SHALL have ports issue_use_rs1_i, issue_use_rs2_i, issue_wr_i, each input 1, marking which operands are live.
REQ-010 SHALL have port reserve_i, input NUM_REGS, carrying the reservation flag of each cell.
REQ-011 SHALL have port w_reserve_o, output NUM_REGS, one-hot reservation request to each cell.
REQ-012 SHALL have ports fu_valid_i in NUM_FU, fu_ready_o out NUM_FU, fu_rd_i in NUM_FU*LEN_REGNO, fu_data_i in NUM_FU*LEN_REG; FU k uses slice k.
REQ-013 SHALL have ports wb_o out NUM_REGS (one-hot writeback select per cell) and wb_data_o out LEN_REG.
REQ-014 SHALL have ports err_o out 1 (sticky protocol error) and stall_cnt_o out 16 (hazard stall count).

Function
REQ-015 issue_ready_o SHALL be combinational: 0 if (use_rs1 & reserve_i[rs1]) | (use_rs2 & reserve_i[rs2]) | (wr & reserve_i[rd]), else 1.
REQ-016 w_reserve_o SHALL be combinational: bit rd set only when the issue fires with issue_wr_i=1; otherwise all 0.
REQ-017 A register with a writeback in flight (wb_o bit set) SHALL still read as reserved via reserve_i; no bypass, stall holds.
REQ-018 Arbiter SHALL grant at most one FU per cycle, round-robin; priority pointer starts at FU0 and moves to (granted+1) mod NUM_FU after each grant.
REQ-019 fu_ready_o SHALL be the one-hot grant, combinational from fu_valid_i and the pointer; FU k transfers when fu_valid_i[k]&fu_ready_o[k].
REQ-020 On a transfer with reserve_i[fu_rd]=1, the next cycle SHALL drive wb_o = one-hot(fu_rd) and wb_data_o = fu_data for exactly one cycle (latency 1, registered).
REQ-021 On a transfer with reserve_i[fu_rd]=0, or fu_rd >= NUM_REGS, the data SHALL be discarded, wb_o stays 0, and err_o SHALL set and hold until reset.
REQ-022 When no transfer occurs, wb_o SHALL be 0 next cycle; wb_data_o holds its last value.
REQ-023 Issue and writeback paths SHALL be independent: both may act in one cycle; WAW stall of REQ-015 guarantees w_reserve_o and wb_o never target the same register.
REQ-024 stall_cnt_o SHALL increment each cycle issue_valid_i=1 and issue_ready_o=0, saturating at 16'hFFFF.
REQ-025 Issue numbers >= NUM_REGS with the matching use/wr bit set SHALL force issue_ready_o=0 and set err_o.

Reset
REQ-026 While rst=1: wb_o=0, wb_data_o=0, err_o=0, stall_cnt_o=0, RR pointer=FU0, asynchronously.
REQ-027 Reset asserted mid-writeback SHALL cancel the pending wb_o pulse; no write reaches any cell.
REQ-028 Combinational outputs SHALL follow REQ-015/016/019 during reset, driven from reserve_i (cells reset to unreserved).

Structure
REQ-029 LEN_REG, LEN_REGNO and NUM_REGS defaults SHALL come from the shared instruction-definition package; no local redefinition.
REQ-030 The round-robin grant and pointer SHALL be a sub-module named rr_arbiter, parameterised by NUM_FU.
REQ-031 Implementation SHALL be one always block for registered state plus combinational hazard/decode logic; no latches.

Verification
REQ-032 Issue rd=3 wr=1, reserve_i=0 -> issue_ready_o=1, w_reserve_o=8'b0000_1000 that cycle.
REQ-033 reserve_i[3]=1, issue use_rs1 rs1=3 for 4 cycles -> issue_ready_o=0 each cycle, stall_cnt_o=4.
REQ-034 FU0 and FU1 valid continuously, rd=2/5 reserved -> grants alternate FU0,FU1,FU0; wb_o 8'h04/8'h20 one cycle after each grant.
REQ-035 FU1 transfer rd=6 with reserve_i[6]=0 -> wb_o stays 0, err_o=1 and stays 1.
REQ-036 rst pulsed the cycle after an FU0 transfer -> wb_o=0, err_o=0, stall_cnt_o=0, next grant goes to FU0.
